complete_arbiter: RTL and testbench

Schedules completed instructions from multiple functional units onto the single complete→retire path. Each FU deposits its finished `CO_RE_PACKET` into a private buffer; every cycle the arbiter picks at most one buffered packet and drives the registered `co_packet` consumed by `retire`. The packet whose `rob_index` matches the ROB head wins outright; otherwise grants rotate round-robin. A squash (branch mispredict) empties every buffer in one cycle.

---
 rtl/complete_arbiter_pkg.sv | 17 +
 rtl/complete_fifo.sv | 74 +++++++
 rtl/complete_arbiter.sv | 141 ++++++++++++++
 tb/tb_complete_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/complete_arbiter_pkg.sv
// Shared complete-stage definitions: ROB sizing and the complete->retire packet.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package complete_arbiter_pkg;

    localparam int ROB_SZ    = 32;
    localparam int ROB_IDX_W = $clog2(ROB_SZ);

    // Packet handed from a functional unit to the complete stage and on to retire.
    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_index;
        logic [5:0]           dest_preg;
        logic [31:0]          value;
    } CO_RE_PACKET;

endpackage

// File: rtl/complete_fifo.sv
// Per-FU buffer of completed packets (DEPTH entries, FIFO order).
// Latency: a push is visible at head the cycle after the push edge; no bypass.
// Backpressure: push is ignored while full; pop ignored while empty; flush/reset empty it in one edge.
//
// Ports: clock/reset (sync, active-high), flush, push + push_data, pop,
//        head (oldest entry, meaningless when empty), count, full, empty.
module complete_fifo
    import complete_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  CO_RE_PACKET      push_data,
    input  logic             pop,
    output CO_RE_PACKET      head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    CO_RE_PACKET      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush && !reset;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/complete_arbiter.sv
// Arbitrates buffered FU completions onto the single registered complete->retire packet.
// Latency: 2 cycles from fu_packet presentation to co_packet (buffer, then registered grant).
// Backpressure: fu_ready[i] low while buffer i is full (count at cycle start), in reset or squash.
//
// Ports: clock/reset (sync, active-high); fu_packet[i]/fu_ready[i] per-FU request/accept;
//        rob_head (ROB head for priority grant); squash (flush all buffers);
//        co_packet/co_grant registered winner packet and one-hot source.
module complete_arbiter
    import complete_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  CO_RE_PACKET          fu_packet [NUM_REQ],
    output logic [NUM_REQ-1:0]   fu_ready,
    input  logic [ROB_IDX_W-1:0] rob_head,
    input  logic                 squash,
    output CO_RE_PACKET          co_packet,
    output logic [NUM_REQ-1:0]   co_grant
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    CO_RE_PACKET        head  [NUM_REQ];
    logic [CNT_W-1:0]   count [NUM_REQ];
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] empty;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] match;

    logic               match_found;
    logic               rr_found;
    logic               grant;
    logic [IDX_W-1:0]   match_idx;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   slot_idx;
    logic [IDX_W-1:0]   winner;
    int                 slot;

    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    CO_RE_PACKET        co_packet_q, co_packet_d;
    logic [NUM_REQ-1:0] co_grant_q,  co_grant_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_buf
        assign fu_ready[g] = !reset && !squash && (count[g] < CNT_W'(BUF_DEPTH));
        assign push[g]     = fu_packet[g].valid && fu_ready[g];

        complete_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .flush     (squash),
            .push      (push[g]),
            .push_data (fu_packet[g]),
            .pop       (pop[g]),
            .head      (head[g]),
            .count     (count[g]),
            .full      (full[g]),
            .empty     (empty[g])
        );

        always_ff @(posedge clock) begin
            if (!reset) assert (full[g] == (count[g] == CNT_W'(BUF_DEPTH)));
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            match[i] = !empty[i] && (head[i].rob_index == rob_head);
        end
    end

    // Both scans run from the far end so the last hit, i.e. the lowest index
    // (or the slot closest to rr_ptr), is the one that sticks.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (match[i]) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
        end

        rr_found = 1'b0;
        rr_idx   = '0;
        slot     = 0;
        slot_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            slot = int'(rr_ptr_q) + k;
            if (slot >= NUM_REQ) slot = slot - NUM_REQ;
            slot_idx = IDX_W'(slot);
            if (!empty[slot_idx]) begin
                rr_found = 1'b1;
                rr_idx   = slot_idx;
            end
        end

        winner = match_found ? match_idx : rr_idx;
        // A head match implies a candidate, so rr_found alone says "someone is waiting".
        grant  = rr_found && !squash;
        pop    = grant ? (NUM_REQ'(1) << winner) : '0;

        co_grant_d  = pop;
        co_packet_d = '0;
        if (grant) begin
            co_packet_d       = head[winner];
            co_packet_d.valid = 1'b1;
        end

        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            co_packet_q <= '0;
            co_grant_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            co_packet_q <= co_packet_d;
            co_grant_q  <= co_grant_d;
        end
    end

    // Two heads matching the ROB head means the ROB handed out a duplicate index.
    always_ff @(posedge clock) begin
        if (!reset && !squash) assert ($countones(match) <= 1);
    end

    assign co_packet = co_packet_q;
    assign co_grant  = co_grant_q;

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed bench for complete_arbiter with a scoreboard of expected retire packets.
// Latency: checks the 2-cycle presentation-to-output path and per-cycle fu_ready.
// Backpressure: FU0 driver holds its packet while fu_ready[0] is low.
module tb_complete_arbiter;
    import complete_arbiter_pkg::*;

    localparam int NR = 4;

    logic                 clock;
    logic                 reset;
    CO_RE_PACKET          fu_packet [NR];
    logic [NR-1:0]        fu_ready;
    logic [ROB_IDX_W-1:0] rob_head;
    logic                 squash;
    CO_RE_PACKET          co_packet;
    logic [NR-1:0]        co_grant;

    typedef struct {
        CO_RE_PACKET   pkt;
        logic [NR-1:0] grant;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 0;

    complete_arbiter #(.NUM_REQ(NR), .BUF_DEPTH(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .fu_packet (fu_packet),
        .fu_ready  (fu_ready),
        .rob_head  (rob_head),
        .squash    (squash),
        .co_packet (co_packet),
        .co_grant  (co_grant)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic CO_RE_PACKET mk(input int rob);
        CO_RE_PACKET p;
        p.valid     = 1'b1;
        p.rob_index = ROB_IDX_W'(rob);
        p.dest_preg = 6'(rob + 17);
        p.value     = 32'hC0DE_0000 + 32'(rob * 257);
        return p;
    endfunction

    task automatic clear_all();
        for (int i = 0; i < NR; i++) fu_packet[i] = '0;
    endtask

    task automatic exp_push(input CO_RE_PACKET p, input logic [NR-1:0] g);
        exp_t e;
        e.pkt   = p;
        e.grant = g;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every valid output must be the next scoreboard entry; idle cycles carry no grant.
    always @(negedge clock) begin
        if (mon_en) begin
            if (co_packet.valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got rob=%0d grant=%b, required no output",
                             co_packet.rob_index, co_grant);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (co_packet !== mon_e.pkt || co_grant !== mon_e.grant) begin
                        n_fail++;
                        $display("FAIL sb_packet: got pkt=%h grant=%b, required pkt=%h grant=%b",
                                 co_packet, co_grant, mon_e.pkt, mon_e.grant);
                    end
                end
            end else begin
                n_checks++;
                if (co_grant !== '0) begin
                    n_fail++;
                    $display("FAIL sb_idle_grant: got %b, required 0", co_grant);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // FU0 stream and the per-cycle tables for the full-buffer scenario.
    CO_RE_PACKET   f0 [4];
    logic [4:0]    rh_tab  [10] = '{5'd8, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd0, 5'd0, 5'd0};
    logic          rdy_tab [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int            j;

    initial begin
        reset    = 1'b1;
        squash   = 1'b0;
        rob_head = '0;
        clear_all();

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        chk("rst_ready", 64'(fu_ready), 64'h0);
        chk("rst_packet", 64'(co_packet), 64'h0);
        chk("rst_grant", 64'(co_grant), 64'h0);
        @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;
        #1 chk("rst_release_ready", 64'(fu_ready), 64'hf);

        // Single packet latency
        @(negedge clock);
        fu_packet[1] = mk(5);
        exp_push(fu_packet[1], 4'b0010);
        #1 chk("t1_ready1", 64'(fu_ready[1]), 64'h1);
        @(negedge clock);
        clear_all();
        chk("t1_not_yet", 64'(co_packet.valid), 64'h0);
        @(negedge clock);
        chk("t1_valid", 64'(co_packet.valid), 64'h1);
        chk("t1_rob", 64'(co_packet.rob_index), 64'd5);
        chk("t1_grant", 64'(co_grant), 64'b0010);
        @(negedge clock);
        chk("t1_after", 64'(co_packet.valid), 64'h0);

        // Reset pulse to bring rr_ptr back to 0
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        // All four FUs at once, no head match: FU0..FU3 in order
        @(negedge clock);
        for (int i = 0; i < NR; i++) begin
            fu_packet[i] = mk(10 + i);
            exp_push(fu_packet[i], NR'(1) << i);
        end
        @(negedge clock);
        clear_all();
        @(negedge clock);
        chk("t2_first_grant", 64'(co_grant), 64'b0001);
        repeat (4) @(negedge clock);

        // Head match beats round-robin
        rob_head     = 5'd7;
        fu_packet[0] = mk(3);
        fu_packet[2] = mk(7);
        exp_push(fu_packet[2], 4'b0100);
        exp_push(fu_packet[0], 4'b0001);
        @(negedge clock);
        clear_all();
        @(negedge clock);
        chk("t3_head_first", 64'(co_grant), 64'b0100);
        @(negedge clock);
        chk("t3_rr_second", 64'(co_grant), 64'b0001);

        // rr_ptr should now be 1: FU1, FU2, FU0
        rob_head     = 5'd0;
        fu_packet[0] = mk(20);
        fu_packet[1] = mk(21);
        fu_packet[2] = mk(22);
        exp_push(fu_packet[1], 4'b0010);
        exp_push(fu_packet[2], 4'b0100);
        exp_push(fu_packet[0], 4'b0001);
        @(negedge clock);
        clear_all();
        repeat (4) @(negedge clock);

        // FU0 fills its buffer while other FUs win by head match
        for (int k = 0; k < 4; k++) f0[k] = mk(1 + k);
        exp_push(mk(8),  4'b0010);
        exp_push(mk(9),  4'b0010);
        exp_push(mk(10), 4'b0100);
        exp_push(mk(11), 4'b0100);
        exp_push(mk(12), 4'b1000);
        exp_push(mk(13), 4'b1000);
        for (int k = 0; k < 4; k++) exp_push(f0[k], 4'b0001);
        j = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clock);
            clear_all();
            rob_head = (c < 10) ? rh_tab[c] : 5'd0;
            if (c == 0) begin
                fu_packet[1] = mk(8);
                fu_packet[2] = mk(10);
                fu_packet[3] = mk(12);
            end
            if (c == 1) begin
                fu_packet[1] = mk(9);
                fu_packet[2] = mk(11);
                fu_packet[3] = mk(13);
            end
            if (j < 4) fu_packet[0] = f0[j];
            #1;
            if (c < 10) chk($sformatf("t4_ready0_c%0d", c), 64'(fu_ready[0]), 64'(rdy_tab[c]));
            if (fu_packet[0].valid && fu_ready[0]) j++;
        end
        chk("t4_all_accepted", 64'(j), 64'd4);

        // Squash with FU3 presenting
        @(negedge clock);
        clear_all();
        rob_head     = 5'd0;
        fu_packet[0] = mk(1);
        fu_packet[1] = mk(2);
        fu_packet[2] = mk(3);
        exp_push(fu_packet[1], 4'b0010);
        @(negedge clock);
        clear_all();
        @(negedge clock);
        squash       = 1'b1;
        fu_packet[3] = mk(4);
        #1;
        chk("t5_ready_squash", 64'(fu_ready), 64'h0);
        chk("t5_visible_in_squash", 64'(co_packet.valid), 64'h1);
        @(negedge clock);
        squash = 1'b0;
        clear_all();
        #1;
        chk("t5_valid_cleared", 64'(co_packet.valid), 64'h0);
        chk("t5_ready_after", 64'(fu_ready), 64'hf);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("t5_idle_%0d", k), 64'(co_packet.valid), 64'h0);
        end

        // Reset with packets buffered
        @(negedge clock);
        fu_packet[0] = mk(5);
        fu_packet[3] = mk(6);
        exp_push(fu_packet[3], 4'b1000);
        @(negedge clock);
        clear_all();
        @(negedge clock);
        reset = 1'b1;
        #1 chk("t6_ready_in_reset", 64'(fu_ready), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        chk("t6_packet_zero", 64'(co_packet), 64'h0);
        chk("t6_grant_zero", 64'(co_grant), 64'h0);
        #1 chk("t6_ready_release", 64'(fu_ready), 64'hf);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("t6_idle_%0d", k), 64'(co_packet.valid), 64'h0);
        end
        fu_packet[1] = mk(9);
        fu_packet[2] = mk(14);
        exp_push(fu_packet[1], 4'b0010);
        exp_push(fu_packet[2], 4'b0100);
        @(negedge clock);
        clear_all();

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
        @(negedge clock);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
